pwm_captura_angulo: RTL and testbench

- Receive side of the servo PWM link: measures the high time of an incoming 50 Hz servo pulse and converts it back to a 0–180 angle code.
- Inverse of the existing angle-to-PWM generator. Used for loop-back checking of the arm's PWM outputs and for reading externally driven servo commands.
- Also flags out-of-range pulses and loss of signal.

---
 rtl/pwm_servo_defs.sv | 17 +
 rtl/pwm_sync_edge.sv | 32 +++
 rtl/pwm_captura_angulo.sv | 186 ++++++++++++++++++
 tb/tb_pwm_captura_angulo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_servo_defs.sv
// Constants and state encodings shared by the servo PWM generator and the
// PWM capture block, so both sides of the link agree on pulse limits.
package pwm_servo_defs;

    localparam int SERVO_MIN  = 500;    // ticks for angle 0
    localparam int SERVO_MAX  = 2500;   // ticks for angle 180
    localparam int PWM_PERIOD = 20000;  // ticks per 50 Hz frame
    localparam int ANGLE_SPAN = 180;

    typedef enum logic [1:0] {
        ST_ARM       = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_CONV      = 2'd3
    } servo_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall strobes.
// Strobes are suppressed until the chain has refilled after reset.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic settled,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_reg;
    logic [2:0] fill_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            fill_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], din};
            fill_reg <= {fill_reg[1:0], 1'b1};
        end
    end

    // The cleared chain would otherwise fake an edge right after reset.
    assign settled = fill_reg[2];
    assign level   = sync_reg[1];
    assign rise    = settled &  sync_reg[1] & ~sync_reg[2];
    assign fall    = settled & ~sync_reg[1] &  sync_reg[2];

endmodule

// File: rtl/pwm_captura_angulo.sv
// Servo PWM receiver: measures pulse high time in ticks, range-checks it and
// converts it back to a 0..180 angle code; also reports loss of signal.
module pwm_captura_angulo #(
    parameter int CLKS_PER_US = 1,
    parameter int SERVO_MIN   = pwm_servo_defs::SERVO_MIN,
    parameter int SERVO_MAX   = pwm_servo_defs::SERVO_MAX,
    parameter int TOL         = 50,
    parameter int TIMEOUT     = pwm_servo_defs::PWM_PERIOD + 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [7:0]  angle_out,
    output logic [15:0] pulse_width,
    output logic        valid,
    output logic        pulse_err,
    output logic        signal_lost
);

    import pwm_servo_defs::*;

    localparam int SPAN     = SERVO_MAX - SERVO_MIN;
    localparam int LO_LIMIT = SERVO_MIN - TOL;
    localparam int HI_LIMIT = SERVO_MAX + TOL;
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    logic level, settled, rise, fall;

    pwm_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .din     (pwm_in),
        .level   (level),
        .settled (settled),
        .rise    (rise),
        .fall    (fall)
    );

    logic tick;

    generate
        if (CLKS_PER_US <= 1) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            localparam int PW = $clog2(CLKS_PER_US);
            logic [PW-1:0] presc_reg;

            always_ff @(posedge clk) begin
                if (rst || !enable) begin
                    presc_reg <= '0;
                end else if (presc_reg == PW'(CLKS_PER_US - 1)) begin
                    presc_reg <= '0;
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end

            assign tick = (presc_reg == PW'(CLKS_PER_US - 1));
        end
    endgenerate

    logic [TO_W-1:0] to_cnt_reg;
    logic            to_hit;

    // Fires only on the tick that reaches TIMEOUT, not while saturated.
    assign to_hit = enable && tick && !rise && !fall &&
                    (to_cnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            to_cnt_reg <= '0;
        end else if (rise || fall) begin
            to_cnt_reg <= '0;
        end else if (tick && (to_cnt_reg != TO_W'(TIMEOUT))) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    servo_state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ARM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARM:       if (settled && !level) state_next = ST_WAIT_RISE;
            ST_WAIT_RISE: if (rise) state_next = ST_HIGH;
            ST_HIGH:      if (fall) state_next = ST_CONV;
            // A rise during CONV starts the next measurement on the same strobe.
            ST_CONV:      state_next = rise ? ST_HIGH : ST_WAIT_RISE;
            default:      state_next = ST_ARM;
        endcase
        if (to_hit) begin
            state_next = ST_ARM;
        end
        if (!enable) begin
            state_next = ST_ARM;
        end
    end

    logic [15:0] width_cnt_reg, width_inc, w_reg;
    logic        start_meas;

    assign start_meas = (state_next == ST_HIGH) && (state_reg != ST_HIGH);
    assign width_inc  = (tick && (width_cnt_reg != 16'hFFFF)) ?
                        width_cnt_reg + 16'd1 : width_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            width_cnt_reg <= '0;
        end else if (start_meas) begin
            width_cnt_reg <= '0;
        end else if (state_reg == ST_HIGH) begin
            width_cnt_reg <= width_inc;
        end
    end

    // The falling-edge tick still belongs to the pulse, so it is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg <= '0;
        end else if (state_reg == ST_HIGH && fall && enable) begin
            w_reg <= width_inc;
        end
    end

    logic        in_band, accept, reject;
    logic [15:0] w_clamped;
    logic [23:0] d24;
    logic [7:0]  angle_next;

    always_comb begin
        in_band   = 1'b1;
        w_clamped = w_reg;
        if (int'(w_reg) < LO_LIMIT || int'(w_reg) > HI_LIMIT) begin
            in_band = 1'b0;
        end else if (int'(w_reg) < SERVO_MIN) begin
            w_clamped = 16'(SERVO_MIN);
        end else if (int'(w_reg) > SERVO_MAX) begin
            w_clamped = 16'(SERVO_MAX);
        end
        d24        = 24'(w_clamped) - 24'(SERVO_MIN);
        // Ceiling division exactly inverts the generator's floored mapping.
        angle_next = 8'((d24 * 24'(ANGLE_SPAN) + 24'(SPAN - 1)) / 24'(SPAN));
        accept     = enable && (state_reg == ST_CONV) &&  in_band;
        reject     = enable && (state_reg == ST_CONV) && !in_band;
    end

    logic [7:0]  angle_reg;
    logic [15:0] pw_reg;
    logic        valid_reg, err_reg, lost_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            angle_reg <= '0;
            pw_reg    <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            lost_reg  <= 1'b1;
        end else begin
            valid_reg <= accept;
            err_reg   <= reject;
            if (accept) begin
                angle_reg <= angle_next;
                pw_reg    <= w_clamped;
                lost_reg  <= 1'b0;
            end else if (to_hit) begin
                lost_reg  <= 1'b1;
            end
        end
    end

    assign angle_out   = angle_reg;
    assign pulse_width = pw_reg;
    assign valid       = valid_reg;
    assign pulse_err   = err_reg;
    assign signal_lost = lost_reg;

endmodule

// File: tb/tb_pwm_captura_angulo.sv
// Directed-plus-random bench for the servo PWM capture block, checked against
// a behavioural generator/decoder model built from the angle mapping itself.
`timescale 1ns/1ps
module tb_pwm_captura_angulo;

    localparam int SLOW_CLKS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable_a, pwm_a, enable_b, pwm_b;
    logic [7:0]  angle_a, angle_b;
    logic [15:0] width_a, width_b;
    logic        valid_a, valid_b, err_a, err_b, lost_a, lost_b;

    pwm_captura_angulo #(.CLKS_PER_US(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable_a),
        .pwm_in      (pwm_a),
        .angle_out   (angle_a),
        .pulse_width (width_a),
        .valid       (valid_a),
        .pulse_err   (err_a),
        .signal_lost (lost_a)
    );

    pwm_captura_angulo #(.CLKS_PER_US(SLOW_CLKS)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable_b),
        .pwm_in      (pwm_b),
        .angle_out   (angle_b),
        .pulse_width (width_b),
        .valid       (valid_b),
        .pulse_err   (err_b),
        .signal_lost (lost_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int va_q[$];
    int ea_q[$];
    int vb_q[$];
    int eb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of every strobe so counts and latencies can be checked.
    always @(negedge clk) begin
        if (valid_a === 1'b1) va_q.push_back(cyc);
        if (err_a   === 1'b1) ea_q.push_back(cyc);
        if (valid_b === 1'b1) vb_q.push_back(cyc);
        if (err_b   === 1'b1) eb_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Generator side of the link: angle -> pulse width in ticks.
    function automatic int gen_width(input int a);
        return (a * 2000) / 180 + 500;
    endfunction

    // Decoder model: smallest angle whose generated pulse is at least w.
    function automatic int model_angle(input int w);
        for (int a = 0; a <= 180; a++) begin
            if (gen_width(a) >= w) return a;
        end
        return 180;
    endfunction

    // Returns the accepted (clamped) width, or -1 when the pulse is rejected.
    function automatic int model_clamp(input int w);
        if (w < 450 || w > 2550) return -1;
        if (w < 500) return 500;
        if (w > 2500) return 2500;
        return w;
    endfunction

    task automatic pulse_a(input string tag, input int w);
        int nv, ne, fall_at, cl;
        logic [7:0]  old_angle;
        logic [15:0] old_width;
        nv = va_q.size();
        ne = ea_q.size();
        old_angle = angle_a;
        old_width = width_a;
        pwm_a = 1'b1;
        wait_cycles(w);
        pwm_a = 1'b0;
        fall_at = cyc;
        wait_cycles(10);
        cl = model_clamp(w);
        if (cl >= 0) begin
            check({tag, "_valid"}, va_q.size(), nv + 1);
            check({tag, "_noerr"}, ea_q.size(), ne);
            check({tag, "_width"}, width_a, cl);
            check({tag, "_angle"}, angle_a, model_angle(cl));
            if (va_q.size() > nv) check({tag, "_latency"}, va_q[$] - fall_at, 4);
        end else begin
            check({tag, "_err"}, ea_q.size(), ne + 1);
            check({tag, "_novalid"}, va_q.size(), nv);
            check({tag, "_width_hold"}, width_a, old_width);
            check({tag, "_angle_hold"}, angle_a, old_angle);
            if (ea_q.size() > ne) check({tag, "_err_latency"}, ea_q[$] - fall_at, 4);
        end
        $display("pulse %s w=%0d angle=%0d width=%0d valids=%0d errs=%0d",
                 tag, w, angle_a, width_a, va_q.size(), ea_q.size());
    endtask

    initial begin
        int f1, f2, nv, nb, ne, a;

        rst = 1'b1; enable_a = 1'b1; enable_b = 1'b1; pwm_a = 1'b0; pwm_b = 1'b0;
        wait_cycles(4);
        check("rst_angle", angle_a, 0);
        check("rst_width", width_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_err", err_a, 0);
        check("rst_lost", lost_a, 1);
        check("rst_lost_b", lost_b, 1);

        // Pulse already high when reset releases must be ignored.
        pwm_a = 1'b1;
        wait_cycles(300);
        rst = 1'b0;
        wait_cycles(400);
        pwm_a = 1'b0;
        wait_cycles(20);
        check("partial_novalid", va_q.size(), 0);
        check("partial_noerr", ea_q.size(), 0);
        check("partial_lost", lost_a, 1);
        $display("reset-release pulse of 700 ticks done, valids=%0d", va_q.size());
        pulse_a("post_reset", 1000);
        check("post_reset_lost", lost_a, 0);

        // Round-trip through the generator mapping: corners plus random angles.
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: a = 0;
                1: a = 1;
                2: a = 179;
                3: a = 180;
                default: a = int'($urandom_range(0, 180));
            endcase
            pulse_a("sweep", gen_width(a));
            check("sweep_roundtrip", angle_a, a);
        end
        check("sweep_no_err", ea_q.size(), 0);

        pulse_a("tol_low", 470);
        pulse_a("tol_high", 2540);
        pulse_a("rej_low", 449);
        pulse_a("rej_high", 2551);
        pulse_a("rand_width", int'($urandom_range(420, 2580)));

        // Two frames of angle 90: one valid per 20001-tick period.
        nv = va_q.size();
        pwm_a = 1'b1;
        wait_cycles(gen_width(90));
        pwm_a = 1'b0;
        f1 = cyc;
        wait_cycles(20001 - gen_width(90));
        pwm_a = 1'b1;
        wait_cycles(gen_width(90));
        pwm_a = 1'b0;
        f2 = cyc;
        wait_cycles(10);
        check("frame_valid_count", va_q.size(), nv + 2);
        check("frame_width", width_a, 1500);
        check("frame_angle", angle_a, 90);
        if (va_q.size() >= 2) begin
            check("frame_spacing", va_q[$] - va_q[$-1], 20001);
            check("frame_latency", va_q[$] - f2, 4);
        end
        $display("frames fall1=%0d fall2=%0d valids=%0d", f1, f2, va_q.size());

        // Line held low: loss declared 25000 ticks after the fall strobe.
        wait_cycles(f2 + 3 + 25000 - 1 - cyc);
        check("lost_before_timeout", lost_a, 0);
        wait_cycles(1);
        check("lost_at_timeout", lost_a, 1);
        $display("timeout at cycle %0d lost=%0d", cyc, lost_a);
        pulse_a("after_loss", 2000);
        check("after_loss_lost", lost_a, 0);

        // Slow-tick instance: enable dropped in the middle of a pulse.
        nb = vb_q.size();
        ne = eb_q.size();
        pwm_b = 1'b1;
        wait_cycles(2000);
        enable_b = 1'b0;
        wait_cycles(20);
        enable_b = 1'b1;
        wait_cycles(1000);
        pwm_b = 1'b0;
        wait_cycles(40);
        check("b_interrupted_novalid", vb_q.size(), nb);
        check("b_interrupted_noerr", eb_q.size(), ne);
        pwm_b = 1'b1;
        wait_cycles(1500 * SLOW_CLKS);
        pwm_b = 1'b0;
        f1 = cyc;
        wait_cycles(40);
        check("b_valid", vb_q.size(), nb + 1);
        check("b_width", width_b, 1500);
        check("b_angle", angle_b, 90);
        check("b_lost", lost_b, 0);
        if (vb_q.size() > nb) check("b_latency", vb_q[$] - f1, 4);
        $display("slow pulse 1500 ticks angle=%0d width=%0d", angle_b, width_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
